// File: rtl/product_catalog_pkg.sv
// Catalog-wide constants: factory default prices for the first four products.
package catalog_pkg;

    localparam int N_DEFAULT_PRICES = 4;

    function automatic int default_price(input int idx);
        case (idx)
            0:       return 1;
            1:       return 2;
            2:       return 5;
            3:       return 10;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/product_catalog_onehot_decode.sv
// One-hot code to binary index; valid only when exactly one bit is set.
module onehot_decode #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     code,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam int CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (code[i]) begin
                cnt = cnt + CNT_W'(1);
                idx = IDX_W'(i);
            end
        end
    end

    assign valid = (cnt == CNT_W'(1));

endmodule

// File: rtl/product_catalog.sv
// Product price/stock catalog with registered lookup and vend responses.
// Stock tracking is built only when PRODUCT_CATALOG_STOCK_EN is defined.
module product_catalog
    import catalog_pkg::*;
#(
    parameter int N_PRODUCTS = 4,
    parameter int PRICE_W    = 8,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5,
    localparam int IDX_W     = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [N_PRODUCTS-1:0] req_code,
    output logic                  rsp_valid,
    output logic [PRICE_W-1:0]    rsp_price,
    output logic                  rsp_code_err,
    output logic                  rsp_sold_out,
    input  logic                  vend_valid,
    input  logic [N_PRODUCTS-1:0] vend_code,
    output logic                  vend_ack,
    output logic                  vend_err,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [PRICE_W-1:0]    cfg_price,
    input  logic [STOCK_W-1:0]    cfg_stock
);

    logic [PRICE_W-1:0] price [N_PRODUCTS];

    logic             req_ok;
    logic [IDX_W-1:0] req_idx;
    logic             vend_code_ok;
    logic [IDX_W-1:0] vend_idx;
    logic             cfg_hit;
    logic             vend_collide;
    logic             stock_empty;
    logic             vend_reject;

    onehot_decode #(.N(N_PRODUCTS), .IDX_W(IDX_W)) u_req_dec (
        .code  (req_code),
        .valid (req_ok),
        .idx   (req_idx)
    );

    onehot_decode #(.N(N_PRODUCTS), .IDX_W(IDX_W)) u_vend_dec (
        .code  (vend_code),
        .valid (vend_code_ok),
        .idx   (vend_idx)
    );

    assign cfg_hit      = cfg_we && ({1'b0, cfg_idx} < (IDX_W + 1)'(N_PRODUCTS));
    // A config write to the product being sold wins; the sale is rejected.
    assign vend_collide = cfg_hit && vend_code_ok && (cfg_idx == vend_idx);
    assign vend_reject  = !vend_code_ok || vend_collide || stock_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PRODUCTS; i++) begin
                price[i] <= PRICE_W'(default_price(i));
            end
        end else if (cfg_hit) begin
            price[cfg_idx] <= cfg_price;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_price    <= '0;
            rsp_code_err <= 1'b0;
            vend_ack     <= 1'b0;
            vend_err     <= 1'b0;
        end else begin
            rsp_valid <= req_valid;
            vend_ack  <= vend_valid;
            if (req_valid) begin
                rsp_code_err <= !req_ok;
                rsp_price    <= req_ok ? price[req_idx] : '0;
            end
            if (vend_valid) begin
                vend_err <= vend_reject;
            end
        end
    end

`ifdef PRODUCT_CATALOG_STOCK_EN
    logic [STOCK_W-1:0] stock [N_PRODUCTS];
    logic               vend_take;

    assign stock_empty = (stock[vend_idx] == '0);
    assign vend_take   = vend_valid && !vend_reject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PRODUCTS; i++) begin
                stock[i] <= STOCK_W'(STOCK_INIT);
            end
            rsp_sold_out <= 1'b0;
        end else begin
            for (int i = 0; i < N_PRODUCTS; i++) begin
                if (cfg_hit && (cfg_idx == IDX_W'(i))) begin
                    stock[i] <= cfg_stock;
                end else if (vend_take && (vend_idx == IDX_W'(i))) begin
                    stock[i] <= stock[i] - STOCK_W'(1);
                end
            end
            if (req_valid) begin
                rsp_sold_out <= req_ok && (stock[req_idx] == '0);
            end
        end
    end
`else
    logic [STOCK_W-1:0] unused_stock;

    assign unused_stock = cfg_stock ^ STOCK_W'(STOCK_INIT);
    assign stock_empty  = 1'b0;
    assign rsp_sold_out = 1'b0;
`endif

endmodule

// File: tb/tb_product_catalog.sv
// Randomised scoreboard bench for product_catalog against a table-level model.
module tb_product_catalog;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int SW = 4;
    localparam int SI = 5;
`ifdef PRODUCT_CATALOG_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [N-1:0]  req_code = '0;
    logic          rsp_valid;
    logic [PW-1:0] rsp_price;
    logic          rsp_code_err;
    logic          rsp_sold_out;
    logic          vend_valid = 1'b0;
    logic [N-1:0]  vend_code = '0;
    logic          vend_ack;
    logic          vend_err;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [PW-1:0] cfg_price = '0;
    logic [SW-1:0] cfg_stock = '0;

    typedef struct packed {
        logic [PW-1:0] price;
        logic          sold;
        logic          err;
    } rsp_t;

    rsp_t rsp_q[$];
    logic vend_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_price[N];
    int   m_stock[N];

    product_catalog #(.N_PRODUCTS(N), .PRICE_W(PW), .STOCK_W(SW), .STOCK_INIT(SI)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_code     (req_code),
        .rsp_valid    (rsp_valid),
        .rsp_price    (rsp_price),
        .rsp_code_err (rsp_code_err),
        .rsp_sold_out (rsp_sold_out),
        .vend_valid   (vend_valid),
        .vend_code    (vend_code),
        .vend_ack     (vend_ack),
        .vend_err     (vend_err),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_price    (cfg_price),
        .cfg_stock    (cfg_stock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int code_index(input logic [N-1:0] c);
        if ($countones(c) != 1) return -1;
        for (int i = 0; i < N; i++) if (c[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_price = '{1, 2, 5, 10};
        for (int i = 0; i < N; i++) m_stock[i] = SI;
    endtask

    task automatic step(input logic rv, input logic [N-1:0] rc,
                        input logic vv, input logic [N-1:0] vc,
                        input logic cw, input logic [1:0] ci,
                        input logic [PW-1:0] cp, input logic [SW-1:0] cs);
        int   ri;
        int   vi;
        rsp_t e;
        logic verr;
        @(negedge clk);
        req_valid = rv;  req_code = rc;
        vend_valid = vv; vend_code = vc;
        cfg_we = cw; cfg_idx = ci; cfg_price = cp; cfg_stock = cs;
        ri = code_index(rc);
        vi = code_index(vc);
        if (rv) begin
            e = '0;
            if (ri < 0) begin
                e.err = 1'b1;
            end else begin
                e.price = PW'(m_price[ri]);
                e.sold  = STOCK_EN && (m_stock[ri] == 0);
            end
            rsp_q.push_back(e);
        end
        if (vv) begin
            if (vi < 0) verr = 1'b1;
            else verr = (cw && int'(ci) == vi) || (STOCK_EN && m_stock[vi] == 0);
            vend_q.push_back(verr);
            if (!verr && STOCK_EN) m_stock[vi] = m_stock[vi] - 1;
        end
        if (cw && int'(ci) < N) begin
            m_price[ci] = int'(cp);
            m_stock[ci] = int'(cs);
        end
    endtask

    task automatic idle();
        step(0, '0, 0, '0, 0, '0, '0, '0);
    endtask

    task automatic lookup(input int i);
        logic [N-1:0] c;
        c = '0;
        c[i] = 1'b1;
        step(1, c, 0, '0, 0, '0, '0, '0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_price"}, 32'(rsp_price), 0);
        chk({tag, "_rsp_code_err"}, 32'(rsp_code_err), 0);
        chk({tag, "_rsp_sold_out"}, 32'(rsp_sold_out), 0);
        chk({tag, "_vend_ack"}, 32'(vend_ack), 0);
        chk({tag, "_vend_err"}, 32'(vend_err), 0);
    endtask

    // Monitor: every queued expectation must appear exactly one edge after issue.
    initial begin : monitor
        rsp_t e;
        logic ve;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_q.size() > 0) begin
                e = rsp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 1);
                chk("rsp_price", 32'(rsp_price), 32'(e.price));
                chk("rsp_code_err", 32'(rsp_code_err), 32'(e.err));
                chk("rsp_sold_out", 32'(rsp_sold_out), 32'(e.sold));
            end else begin
                chk("rsp_spurious", 32'(rsp_valid), 0);
            end
            if (vend_q.size() > 0) begin
                ve = vend_q.pop_front();
                chk("vend_ack", 32'(vend_ack), 1);
                chk("vend_err", 32'(vend_err), 32'(ve));
            end else begin
                chk("vend_spurious", 32'(vend_ack), 0);
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] rc;
        logic [N-1:0] vc;
        model_reset();
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N; i++) lookup(i);
        step(1, 4'b0000, 0, '0, 0, '0, '0, '0);
        step(1, 4'b0011, 0, '0, 0, '0, '0, '0);

        repeat (6) step(0, '0, 1, 4'b0100, 0, '0, '0, '0);
        lookup(2);
        step(0, '0, 1, 4'b0100, 0, '0, '0, '0);
        lookup(2);
        step(0, '0, 1, 4'b0000, 0, '0, '0, '0);
        step(0, '0, 1, 4'b1010, 0, '0, '0, '0);

        step(1, 4'b0010, 0, '0, 1, 2'd1, 8'd7, 4'd3);
        lookup(1);

        step(0, '0, 1, 4'b0001, 1, 2'd0, 8'd9, 4'd2);
        lookup(0);
        repeat (3) step(0, '0, 1, 4'b0001, 0, '0, '0, '0);
        lookup(0);
        step(1, 4'b1000, 1, 4'b1000, 1, 2'd3, 8'd12, 4'd1);
        lookup(3);

        repeat (400) begin
            rc = ($urandom_range(0, 3) != 0) ? (N'(1) << $urandom_range(0, N - 1)) : N'($urandom);
            vc = ($urandom_range(0, 3) != 0) ? (N'(1) << $urandom_range(0, N - 1)) : N'($urandom);
            step(1'($urandom_range(0, 1)), rc, 1'($urandom_range(0, 1)), vc,
                 ($urandom_range(0, 7) == 0), 2'($urandom), PW'($urandom), SW'($urandom_range(0, 3)));
        end

        step(1, 4'b0100, 1, 4'b0010, 1, 2'd2, 8'd33, 4'd0);
        step(1, 4'b0001, 1, 4'b0001, 0, '0, '0, '0);
        #2;
        rst = 1'b1;
        rsp_q.delete();
        vend_q.delete();
        req_valid = 1'b0; vend_valid = 1'b0; cfg_we = 1'b0;
        #1;
        check_outputs_zero("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) lookup(i);
        repeat (2) step(0, '0, 1, 4'b0100, 0, '0, '0, '0);
        lookup(2);
        idle();
        idle();
        @(negedge clk);

        chk("rsp_queue_drained", 32'(rsp_q.size()), 0);
        chk("vend_queue_drained", 32'(vend_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
